noc_local_packetizer: RTL and testbench



---
 rtl/noc_local_packetizer.sv | 145 ++++++++++++++
 tb/tb_noc_local_packetizer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_packetizer.sv
// Injection-side packetizer: turns a send command plus payload stream into a header flit followed
// by payload flits on one virtual channel of the router LOCAL input port.
module noc_local_packetizer #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned X          = 4,
    parameter int unsigned Y          = 4,
    parameter int unsigned SRC_ID     = 0,
    parameter int unsigned MAX_LEN    = 16,
    localparam int unsigned VC_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned NODES     = X * Y,
    localparam int unsigned DW        = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DW-1:0]         cmd_dest,
    input  logic [VC_W-1:0]       cmd_vc,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [FLIT_WIDTH-1:0] data_flit,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
    output logic                  cmd_err,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

    state_e                  state_q, state_d;
    logic [VC_W-1:0]         vc_q, vc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    reg_valid_q, reg_valid_d;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
    logic                    last_q, last_d;
    logic                    cmd_err_q, cmd_err_d;

    logic                    cmd_ok;
    logic                    handshake;
    logic                    data_ready_int;
    logic                    data_accept;
    logic [FLIT_WIDTH-1:0]   hdr;

    always_comb begin
        cmd_ok = (32'(cmd_len) <= MAX_LEN) && (32'(cmd_dest) < NODES) &&
                 (32'(cmd_vc) < CHANNELS);

        hdr = '0;
        hdr[FLIT_WIDTH-1 -: DW]    = cmd_dest;
        hdr[FLIT_WIDTH-DW-1 -: DW] = DW'(SRC_ID);
        hdr[LEN_W-1:0]             = cmd_len;

        handshake = reg_valid_q & out_ready[vc_q];
        // Header drain may overlap the first payload load so the packet streams without a bubble.
        data_ready_int = (state_q != StIdle) && (cnt_q != '0) && (!reg_valid_q || handshake);
        data_accept    = data_valid & data_ready_int;
    end

    always_comb begin
        state_d     = state_q;
        vc_d        = vc_q;
        cnt_d       = cnt_q;
        reg_valid_d = reg_valid_q;
        flit_d      = flit_q;
        last_d      = last_q;
        cmd_err_d   = 1'b0;

        if (handshake) begin
            reg_valid_d = 1'b0;
        end
        if (data_accept) begin
            reg_valid_d = 1'b1;
            flit_d      = data_flit;
            last_d      = (cnt_q == LEN_W'(1));
            cnt_d       = cnt_q - LEN_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        vc_d        = cmd_vc;
                        cnt_d       = cmd_len;
                        reg_valid_d = 1'b1;
                        flit_d      = hdr;
                        last_d      = (cmd_len == '0);
                        state_d     = StHdr;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StHdr: begin
                if (handshake) begin
                    state_d = last_q ? StIdle : StBody;
                end
            end
            StBody: begin
                if (handshake && last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            vc_q        <= '0;
            cnt_q       <= '0;
            reg_valid_q <= 1'b0;
            flit_q      <= '0;
            last_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vc_q        <= vc_d;
            cnt_q       <= cnt_d;
            reg_valid_q <= reg_valid_d;
            flit_q      <= flit_d;
            last_q      <= last_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        // State is forced to idle by reset, so only cmd_ready needs explicit gating.
        cmd_ready  = (state_q == StIdle) && !rst;
        data_ready = data_ready_int;
        out_flit   = flit_q;
        out_last   = last_q;
        cmd_err    = cmd_err_q;
        busy       = (state_q != StIdle);
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            out_valid[i] = reg_valid_q && (32'(vc_q) == i);
        end
    end

endmodule

// File: tb/tb_noc_local_packetizer.sv
// Directed bench for noc_local_packetizer: queue-based expected-flit model checked every cycle,
// plus literal expectations for each scenario.
module tb_noc_local_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_dest;
    logic [0:0]  cmd_vc;
    logic [4:0]  cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_flit;
    logic [31:0] out_flit;
    logic        out_last;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic        cmd_err;
    logic        busy;

    noc_local_packetizer #(
        .FLIT_WIDTH(32),
        .CHANNELS  (2),
        .X         (4),
        .Y         (4),
        .SRC_ID    (0),
        .MAX_LEN   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dest  (cmd_dest),
        .cmd_vc    (cmd_vc),
        .cmd_len   (cmd_len),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_flit (data_flit),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] flit;
        logic        last;
        logic [1:0]  vc_oh;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] log_flit[$];
    logic        log_last[$];
    int          log_cyc[$];
    bit          busy_hist[int];
    bit          pend_err = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] hdr_of(input int dest, input int len);
        return (32'(dest) << 28) | (32'(0) << 24) | 32'(len);
    endfunction

    task automatic push_packet(input int dest, input int vc, input int len,
                               input logic [31:0] pl[$]);
        item_t it;
        it.flit  = hdr_of(dest, len);
        it.last  = (len == 0);
        it.vc_oh = 2'(1 << vc);
        exp_q.push_back(it);
        for (int i = 0; i < len; i++) begin
            it.flit = pl[i];
            it.last = (i == len - 1);
            exp_q.push_back(it);
        end
    endtask

    // Per-cycle comparison against the expected-flit queue.
    always @(negedge clk) begin
        busy_hist[cyc] = busy;
        if (rst) begin
            chk("reset_outputs", {out_valid, out_last, out_flit, cmd_ready, data_ready, cmd_err,
                                  busy} == '0, 1);
            exp_q.delete();
            pend_err = 1'b0;
        end else begin
            chk("cmd_err", cmd_err, pend_err);
            pend_err = cmd_valid && cmd_ready &&
                       (cmd_len > 16 || cmd_dest >= 16 || cmd_vc >= 2);
            if (out_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {30'b0, out_valid}, 0);
                end else begin
                    chk("out_valid", {30'b0, out_valid}, {30'b0, exp_q[0].vc_oh});
                    chk("out_flit", out_flit, exp_q[0].flit);
                    chk("out_last", out_last, exp_q[0].last);
                    if ((out_valid & out_ready) != 2'b00) begin
                        log_flit.push_back(out_flit);
                        log_last.push_back(out_last);
                        log_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_cmd(input int dest, input int vc, input int len);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_dest  = 4'(dest);
        cmd_vc    = 1'(vc);
        cmd_len   = 5'(len);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_data(input logic [31:0] pl[$]);
        data_valid = 1'b1;
        foreach (pl[k]) begin
            bit ok = 1'b0;
            data_flit = pl[k];
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (data_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("data_accept_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    task automatic send_packet(input int dest, input int vc, input int len,
                               input logic [31:0] pl[$]);
        push_packet(dest, vc, len, pl);
        do_cmd(dest, vc, len);
        if (len > 0) send_data(pl);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] f,
                           input logic l);
        if (idx >= log_flit.size()) begin
            chk({name, "_missing"}, 32'(log_flit.size()), 32'(idx + 1));
        end else begin
            chk(name, {log_flit[idx][30:0], log_last[idx]}, {f[30:0], l});
            chk({name, "_msb"}, log_flit[idx], f);
        end
    endtask

    task automatic chk_consecutive(input string name, input int s, input int n);
        for (int k = 1; k < n; k++) begin
            if (s + k < log_cyc.size()) chk(name, log_cyc[s + k] - log_cyc[s], k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pl[$];
        int s;
        int h;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dest   = '0;
        cmd_vc     = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data_flit  = '0;
        out_ready  = 2'b00;

        // Reset held 3 cycles with random inputs.
        repeat (3) begin
            @(posedge clk);
            #1;
            cmd_valid  = 1'($urandom);
            cmd_dest   = 4'($urandom);
            cmd_vc     = 1'($urandom);
            cmd_len    = 5'($urandom);
            data_valid = 1'($urandom);
            data_flit  = $urandom;
            out_ready  = 2'($urandom);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
        out_ready  = 2'b11;
        @(negedge clk);
        chk("cmd_ready_after_reset", cmd_ready, 1);
        chk("busy_after_reset", busy, 0);
        @(posedge clk);
        #1;

        // Basic packet.
        pl.delete();
        pl.push_back(32'hA1);
        pl.push_back(32'hA2);
        pl.push_back(32'hA3);
        s = log_flit.size();
        send_packet(5, 1, 3, pl);
        wait_drain();
        chk_log("basic_hdr", s, 32'h5000_0003, 1'b0);
        chk_log("basic_p1", s + 1, 32'hA1, 1'b0);
        chk_log("basic_p2", s + 2, 32'hA2, 1'b0);
        chk_log("basic_p3", s + 3, 32'hA3, 1'b1);
        chk_consecutive("basic_back_to_back", s, 4);

        // Back-pressure on VC1 while A1 is held.
        s = log_flit.size();
        fork
            send_packet(5, 1, 3, pl);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (data_valid && data_ready && data_flit == 32'hA1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("bp_a1_accepted", seen, 1);
                @(posedge clk);
                #1;
                out_ready = 2'b01;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_held_flit", out_flit, 32'hA1);
                    chk("bp_held_valid", {30'b0, out_valid}, 32'h2);
                    chk("bp_data_ready_low", data_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 2'b11;
            end
        join
        wait_drain();
        chk_log("bp_hdr", s, 32'h5000_0003, 1'b0);
        chk_log("bp_p1", s + 1, 32'hA1, 1'b0);
        chk_log("bp_p2", s + 2, 32'hA2, 1'b0);
        chk_log("bp_p3", s + 3, 32'hA3, 1'b1);
        chk("bp_count", 32'(log_flit.size() - s), 4);

        // Two header-only packets back to back.
        pl.delete();
        s = log_flit.size();
        push_packet(15, 0, 0, pl);
        push_packet(3, 1, 0, pl);
        do_cmd(15, 0, 0);
        do_cmd(3, 1, 0);
        wait_drain();
        chk_log("hdr_only_1", s, 32'hF000_0000, 1'b1);
        chk_log("hdr_only_2", s + 1, 32'h3000_0000, 1'b1);
        if (s + 1 < log_cyc.size()) begin
            h = log_cyc[s];
            chk("hdr_only_gap", log_cyc[s + 1] - h, 2);
            chk("busy_at_hs", busy_hist[h], 1);
            chk("busy_gap", busy_hist[h + 1], 0);
            chk("busy_next", busy_hist[h + 2], 1);
        end

        // Rejected command then a legal one.
        do_cmd(2, 0, 17);
        @(negedge clk);
        chk("reject_err_pulse", cmd_err, 1);
        chk("reject_no_busy", busy, 0);
        @(negedge clk);
        chk("reject_err_clear", cmd_err, 0);
        chk("reject_no_valid", {30'b0, out_valid}, 0);
        @(posedge clk);
        #1;
        pl.delete();
        pl.push_back(32'h77);
        s = log_flit.size();
        send_packet(2, 0, 1, pl);
        wait_drain();
        chk_log("after_reject_hdr", s, 32'h2000_0001, 1'b0);
        chk_log("after_reject_p1", s + 1, 32'h77, 1'b1);

        // Reset in the middle of a body.
        pl.delete();
        pl.push_back(32'hB1);
        pl.push_back(32'hB2);
        pl.push_back(32'hB3);
        push_packet(6, 1, 3, pl);
        do_cmd(6, 1, 3);
        pl.delete();
        pl.push_back(32'hB1);
        send_data(pl);
        chk("mid_b1_flit", out_flit, 32'hB1);
        chk("mid_b1_valid", {30'b0, out_valid}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid_clear", {30'b0, out_valid}, 0);
        chk("async_flit_clear", out_flit, 0);
        chk("async_busy_clear", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pl.delete();
        pl.push_back(32'hC1);
        pl.push_back(32'hC2);
        s = log_flit.size();
        send_packet(9, 0, 2, pl);
        wait_drain();
        chk_log("post_reset_hdr", s, 32'h9000_0002, 1'b0);
        chk_log("post_reset_p1", s + 1, 32'hC1, 1'b0);
        chk_log("post_reset_p2", s + 2, 32'hC2, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
